// File: rtl/spi_arb_pkg.sv
// Shared types for the SPI transaction arbiter.
// Holds the sequencer state enum, byte-count type and its legality check.
package spi_arb_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_GRANT,
    S_ACTIVE,
    S_DRAIN,
    S_GUARD
  } state_t;

  localparam int SPI_MAX_BYTES = 4;

  typedef logic [2:0] nbytes_t;

  function automatic logic bytes_ok(nbytes_t b);
    return (b != '0) && (b <= nbytes_t'(SPI_MAX_BYTES));
  endfunction

endpackage

// File: rtl/spi_txn_arbiter_rr_pick.sv
// rr_pick: combinational round-robin select, first req at/after ptr.
// Ports: req, ptr in; one-hot gnt, its idx, and valid out.
module rr_pick #(
  parameter int N = 4
) (
  input  logic [N-1:0]         req,
  input  logic [$clog2(N)-1:0] ptr,
  output logic [N-1:0]         gnt,
  output logic [$clog2(N)-1:0] idx,
  output logic                 valid
);

  localparam int IW = $clog2(N);

  always_comb begin
    int j;
    j     = 0;
    gnt   = '0;
    idx   = '0;
    valid = 1'b0;
    for (int i = 0; i < N; i++) begin
      j = (int'(ptr) + i) % N;
      if (!valid && req[j]) begin
        valid  = 1'b1;
        gnt[j] = 1'b1;
        idx    = IW'(j);
      end
    end
  end

endmodule

// File: rtl/spi_txn_arbiter.sv
// spi_txn_arbiter: shares one SPI master among N_REQ requesters.
// Ports: req/wdata/bytes in, gnt/done/err/rdata out, cs_n + master side.
module spi_txn_arbiter
  import spi_arb_pkg::*;
#(
  parameter int N_REQ    = 4,
  parameter int CS_SETUP = 4,
  parameter int CS_GUARD = 8,
  parameter int TIMEOUT  = 4096
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic [N_REQ-1:0]   req_i,
  input  logic [32*N_REQ-1:0] req_wdata_i,
  input  logic [3*N_REQ-1:0] req_bytes_i,
  output logic [N_REQ-1:0]   gnt_o,
  output logic [N_REQ-1:0]   done_o,
  output logic               err_o,
  output logic [31:0]        rdata_o,
  output logic [N_REQ-1:0]   cs_n_o,
  output logic               spi_en_o,
  output logic [31:0]        spi_wdata_o,
  output logic [2:0]         spi_wbytes_o,
  input  logic               spi_ready_i,
  input  logic [31:0]        spi_rdata_i,
  input  logic [2:0]         spi_rbytes_i
);

  localparam int IW   = $clog2(N_REQ);
  localparam int M1   = (CS_SETUP > CS_GUARD) ? CS_SETUP : CS_GUARD;
  localparam int MAXC = (M1 > TIMEOUT) ? M1 : TIMEOUT;
  localparam int CW   = $clog2(MAXC) + 1;

  state_t            state;
  logic [CW-1:0]     cnt;
  logic [IW-1:0]     cur;
  logic [IW-1:0]     rr_ptr;

  logic [N_REQ-1:0]  pick_gnt;
  logic [IW-1:0]     pick_idx;
  logic              pick_vld;
  logic [31:0]       sel_wdata;
  nbytes_t           sel_bytes;

  logic              abort;
  logic              complete;
  logic              tmo;

  rr_pick #(.N(N_REQ)) u_pick (
    .req   (req_i),
    .ptr   (rr_ptr),
    .gnt   (pick_gnt),
    .idx   (pick_idx),
    .valid (pick_vld)
  );

  assign sel_wdata = req_wdata_i[32*pick_idx +: 32];
  assign sel_bytes = req_bytes_i[3*pick_idx +: 3];

  // Abort outranks completion and timeout in the same cycle.
  assign abort    = ~req_i[cur];
  assign complete = ~abort && (spi_rbytes_i == spi_wbytes_o);
  assign tmo      = ~abort && ~complete
                    && (cnt == CW'(TIMEOUT - 1));

  function automatic logic [IW-1:0] nxt(logic [IW-1:0] i);
    return (i == IW'(N_REQ - 1)) ? '0 : i + IW'(1);
  endfunction

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state        <= S_IDLE;
      cnt          <= '0;
      cur          <= '0;
      rr_ptr       <= '0;
      gnt_o        <= '0;
      done_o       <= '0;
      err_o        <= 1'b0;
      rdata_o      <= '0;
      cs_n_o       <= '1;
      spi_en_o     <= 1'b0;
      spi_wdata_o  <= '0;
      spi_wbytes_o <= '0;
    end else begin
      done_o <= '0;
      err_o  <= 1'b0;
      unique case (state)
        S_IDLE: begin
          if (pick_vld && spi_ready_i) begin
            if (!bytes_ok(sel_bytes)) begin
              // Illegal count: answer at once, no bus activity.
              done_o <= pick_gnt;
              err_o  <= 1'b1;
              rr_ptr <= nxt(pick_idx);
            end else begin
              cur          <= pick_idx;
              gnt_o        <= pick_gnt;
              cs_n_o       <= ~pick_gnt;
              spi_wdata_o  <= sel_wdata;
              spi_wbytes_o <= sel_bytes;
              cnt          <= '0;
              state        <= S_GRANT;
            end
          end
        end
        S_GRANT: begin
          if (cnt == CW'(CS_SETUP - 1)) begin
            spi_en_o <= 1'b1;
            cnt      <= '0;
            state    <= S_ACTIVE;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        S_ACTIVE: begin
          if (abort || complete || tmo) begin
            if (!abort) done_o <= gnt_o;
            if (complete) rdata_o <= spi_rdata_i;
            err_o    <= tmo;
            spi_en_o <= 1'b0;
            gnt_o    <= '0;
            cs_n_o   <= '1;
            rr_ptr   <= nxt(cur);
            cnt      <= '0;
            state    <= S_DRAIN;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        S_DRAIN: begin
          if (spi_ready_i && spi_rbytes_i == '0) begin
            cnt   <= '0;
            state <= S_GUARD;
          end
        end
        S_GUARD: begin
          if (cnt == CW'(CS_GUARD - 1)) begin
            cnt   <= '0;
            state <= S_IDLE;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_spi_txn_arbiter.sv
// Bench for spi_txn_arbiter: timestamp-based reference model plus
// directed literal scenarios and a randomized requester/master phase.
module tb_spi_txn_arbiter;

  localparam int N   = 4;
  localparam int CSS = 4;
  localparam int CSG = 8;
  localparam int TMO = 64;

  logic           clk = 1'b0;
  logic           rst;
  logic [N-1:0]   req;
  logic [32*N-1:0] req_wdata;
  logic [3*N-1:0] req_bytes;
  logic [N-1:0]   gnt, done, cs_n;
  logic           err, spi_en, spi_ready;
  logic [31:0]    rdata, spi_wdata, spi_rdata;
  logic [2:0]     spi_wbytes, spi_rbytes;

  always #5 clk = ~clk;

  spi_txn_arbiter #(
    .N_REQ(N), .CS_SETUP(CSS), .CS_GUARD(CSG), .TIMEOUT(TMO)
  ) dut (
    .clk_i(clk), .rst_i(rst), .req_i(req),
    .req_wdata_i(req_wdata), .req_bytes_i(req_bytes),
    .gnt_o(gnt), .done_o(done), .err_o(err), .rdata_o(rdata),
    .cs_n_o(cs_n), .spi_en_o(spi_en), .spi_wdata_o(spi_wdata),
    .spi_wbytes_o(spi_wbytes), .spi_ready_i(spi_ready),
    .spi_rdata_i(spi_rdata), .spi_rbytes_i(spi_rbytes)
  );

  int checks = 0;
  int failures = 0;

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h at %0t",
               name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  int cyc = 0;
  int owner, t_grant, t_en, t_end, free_at, mptr;
  bit draining;
  bit mvalid = 0;
  logic [N-1:0] e_gnt, e_done, e_cs_n;
  logic         e_err, e_en;
  logic [31:0]  e_rdata, e_wdata;
  logic [2:0]   e_wbytes;

  task automatic model_reset();
    owner = -1; t_grant = 0; t_en = 0; t_end = 0;
    free_at = 0; mptr = 0; draining = 0;
    e_gnt = '0; e_done = '0; e_cs_n = '1; e_err = 0; e_en = 0;
    e_rdata = '0; e_wdata = '0; e_wbytes = '0;
  endtask

  task automatic end_txn();
    e_en = 0; e_gnt = '0; e_cs_n = '1;
    mptr = (owner + 1) % N;
    owner = -1; draining = 1; t_end = cyc;
  endtask

  initial begin
    model_reset();
    forever begin
      @(posedge clk);
      cyc++;
      e_done = '0;
      e_err  = 0;
      if (rst) begin
        model_reset();
        mvalid = 1;
      end else if (owner >= 0) begin
        if (!e_en) begin
          if (cyc - t_grant == CSS) begin
            e_en = 1; t_en = cyc;
          end
        end else if (!req[owner]) begin
          end_txn();
        end else if (spi_rbytes == e_wbytes) begin
          e_rdata = spi_rdata;
          e_done[owner] = 1'b1;
          end_txn();
        end else if (cyc - t_en == TMO) begin
          e_done[owner] = 1'b1;
          e_err = 1;
          end_txn();
        end
      end else if (draining) begin
        if (spi_ready && spi_rbytes == 3'd0) begin
          draining = 0;
          free_at = cyc + CSG + 1;
        end
      end else if (cyc >= free_at && req != '0 && spi_ready) begin
        int k;
        logic [2:0] b;
        k = -1;
        for (int i = 0; i < N; i++)
          if (k < 0 && req[(mptr + i) % N]) k = (mptr + i) % N;
        b = req_bytes[3*k +: 3];
        if (b == 3'd0 || b > 3'd4) begin
          e_done[k] = 1'b1;
          e_err = 1;
          mptr = (k + 1) % N;
        end else begin
          owner = k; t_grant = cyc;
          e_gnt = '0; e_gnt[k] = 1'b1;
          e_cs_n = ~e_gnt;
          e_wdata = req_wdata[32*k +: 32];
          e_wbytes = b;
        end
      end
    end
  end

  always @(negedge clk) begin
    if (mvalid) begin
      chk("gnt", 32'(gnt), 32'(e_gnt));
      chk("done", 32'(done), 32'(e_done));
      chk("err", 32'(err), 32'(e_err));
      chk("cs_n", 32'(cs_n), 32'(e_cs_n));
      chk("spi_en", 32'(spi_en), 32'(e_en));
      chk("rdata", rdata, e_rdata);
      if (e_en) begin
        chk("spi_wdata", spi_wdata, e_wdata);
        chk("spi_wbytes", 32'(spi_wbytes), 32'(e_wbytes));
      end
    end
  end

  // ---------------- SPI master model ----------------
  bit m_busy = 0, m_stall = 0, m_wild = 0, m_frc = 0;
  logic [31:0] m_frc_val = '0;
  int m_lat = 0, m_rel = 0;

  initial begin
    spi_ready = 1; spi_rbytes = '0; spi_rdata = '0;
    forever begin
      @(negedge clk);
      if (rst) begin
        m_busy = 0; spi_ready = 1; spi_rbytes = '0;
      end else if (m_busy) begin
        if (!spi_en) begin
          if (m_rel <= 0) begin
            m_busy = 0; spi_ready = 1; spi_rbytes = '0;
          end else m_rel--;
        end else if (m_lat > 0) m_lat--;
        else if (m_lat == 0) begin
          spi_rbytes = spi_wbytes;
          spi_rdata = m_frc ? m_frc_val : $urandom;
          m_lat = -1;
        end
      end else if (spi_en) begin
        m_busy = 1; spi_ready = 0;
        m_rel = $urandom_range(0, 4);
        if (m_stall || (m_wild && $urandom_range(0, 15) == 0))
          m_lat = -1;
        else
          m_lat = $urandom_range(0, 8);
      end
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic set_req(int k, logic [31:0] w, logic [2:0] b);
    req_wdata[32*k +: 32] = w;
    req_bytes[3*k +: 3] = b;
    req[k] = 1'b1;
  endtask

  function automatic logic [2:0] rand_bytes();
    int r;
    r = $urandom_range(0, 9);
    if (r < 8) return 3'($urandom_range(1, 4));
    if (r == 8) return 3'd0;
    return 3'($urandom_range(5, 7));
  endfunction

  function automatic int oh2i(logic [N-1:0] v);
    for (int i = 0; i < N; i++) if (v[i]) return i;
    return -1;
  endfunction

  task automatic settle();
    repeat (40) @(negedge clk);
  endtask

  task automatic do_reset();
    rst = 1; req = '0;
    repeat (2) @(negedge clk);
    rst = 0;
  endtask

  task automatic wait_en(string name);
    int n;
    n = 0;
    while (!spi_en && n < 30) begin @(negedge clk); n++; end
    chk(name, 32'(spi_en), 32'd1);
  endtask

  task automatic finish_req(int k, string name);
    int n;
    n = 0;
    while (!done[k] && n < 200) begin @(negedge clk); n++; end
    chk(name, 32'(done[k]), 32'd1);
    req[k] = 1'b0;
  endtask

  // ---------------- directed + random ----------------
  initial begin
    int n, nd, ng, gap, prev_g;
    bit csok;
    int order [5];
    int exp_order [5];
    exp_order = '{0, 1, 2, 3, 0};

    rst = 1; req = '0; req_wdata = '0; req_bytes = '0;
    repeat (3) @(negedge clk);
    chk("rst_gnt", 32'(gnt), 32'd0);
    chk("rst_cs_n", 32'(cs_n), 32'hF);
    chk("rst_en", 32'(spi_en), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_err", 32'(err), 32'd0);
    chk("rst_rdata", rdata, 32'd0);
    rst = 0;

    // single requester 2, two bytes
    m_frc = 1; m_frc_val = 32'h3C7E_0000;
    set_req(2, 32'hA5C3_0F11, 3'd2);
    @(negedge clk);
    chk("t1_gnt", 32'(gnt), 32'b0100);
    chk("t1_cs_n", 32'(cs_n), 32'b1011);
    n = 0;
    while (!spi_en && n < 20) begin @(negedge clk); n++; end
    chk("t1_setup", 32'(n), 32'd4);
    chk("t1_wdata", spi_wdata, 32'hA5C3_0F11);
    n = 0;
    while (done == '0 && n < 100) begin @(negedge clk); n++; end
    chk("t1_done", 32'(done), 32'b0100);
    chk("t1_err", 32'(err), 32'd0);
    chk("t1_rdata", 32'(rdata[31:16]), 32'h3C7E);
    chk("t1_en_fall", 32'(spi_en), 32'd0);
    req[2] = 0;
    nd = 0;
    repeat (40) begin @(negedge clk); if (done != '0) nd++; end
    chk("t1_done_once", 32'(nd), 32'd0);
    m_frc = 0;

    // illegal byte counts from requester 1
    set_req(1, 32'h0, 3'd0);
    @(negedge clk);
    chk("e0_done", 32'(done), 32'b0010);
    chk("e0_err", 32'(err), 32'd1);
    chk("e0_cs_n", 32'(cs_n), 32'hF);
    chk("e0_en", 32'(spi_en), 32'd0);
    req[1] = 0;
    @(negedge clk);
    set_req(1, 32'h0, 3'd5);
    @(negedge clk);
    chk("e5_done", 32'(done), 32'b0010);
    chk("e5_err", 32'(err), 32'd1);
    chk("e5_cs_n", 32'(cs_n), 32'hF);
    req[1] = 0;
    @(negedge clk);
    for (int k = 0; k < N; k++) set_req(k, $urandom, 3'd1);
    @(negedge clk);
    chk("ptr_after_err", 32'(gnt), 32'b0100);

    // all four holding requests from a clean reset
    do_reset();
    for (int k = 0; k < N; k++) set_req(k, $urandom, 3'd1);
    ng = 0; n = 0; gap = 0; prev_g = 0; csok = 1;
    while (ng < 5 && n < 2000) begin
      @(negedge clk); n++;
      if (gnt != '0 && prev_g == 0) begin
        order[ng] = oh2i(gnt);
        if (ng > 0) begin
          chk("rr_gap", 32'(gap >= CSG), 32'd1);
          chk("rr_gap_cs", 32'(csok), 32'd1);
        end
        ng++; gap = 0; csok = 1;
      end else if (gnt == '0) begin
        gap++;
        if (cs_n != 4'hF) csok = 0;
      end
      prev_g = (gnt != '0) ? 1 : 0;
    end
    chk("rr_count", 32'(ng), 32'd5);
    for (int i = 0; i < 5; i++)
      chk("rr_order", 32'(order[i]), 32'(exp_order[i]));
    req = '0;
    settle();

    // abort of a 4-byte transfer by requester 0
    do_reset();
    m_stall = 1;
    set_req(0, $urandom, 3'd4);
    wait_en("ab_en");
    repeat (3) @(negedge clk);
    req[0] = 0;
    set_req(1, 32'h0, 3'd1);
    @(negedge clk);
    chk("ab_en_fall", 32'(spi_en), 32'd0);
    chk("ab_no_done", 32'(done), 32'd0);
    chk("ab_gnt_drop", 32'(gnt), 32'd0);
    m_stall = 0;
    m_frc = 1; m_frc_val = 32'h1234_5678;
    n = 0; nd = 0;
    while (gnt == '0 && n < 100) begin
      @(negedge clk); n++;
      if (done != '0) nd++;
    end
    chk("ab_next_gnt", 32'(gnt), 32'b0010);
    chk("ab_gap_done", 32'(nd), 32'd0);
    chk("ab_guard", 32'(n >= CSG), 32'd1);
    finish_req(1, "ab_req1_done");
    m_frc = 0;
    settle();

    // timeout on requester 3
    m_stall = 1;
    set_req(3, $urandom, 3'd3);
    wait_en("to_en");
    n = 0;
    while (done == '0 && n < 200) begin @(negedge clk); n++; end
    chk("to_cycles", 32'(n), 32'd64);
    chk("to_done", 32'(done), 32'b1000);
    chk("to_err", 32'(err), 32'd1);
    chk("to_rdata", rdata, 32'h1234_5678);
    req[3] = 0;
    m_stall = 0;
    settle();

    // move the pointer to 2, then reset mid-transfer of requester 2
    set_req(1, $urandom, 3'd1);
    finish_req(1, "rs_req1_done");
    settle();
    m_stall = 1;
    set_req(2, $urandom, 3'd2);
    wait_en("rs_en");
    repeat (2) @(negedge clk);
    rst = 1;
    @(negedge clk);
    chk("rs_gnt", 32'(gnt), 32'd0);
    chk("rs_done", 32'(done), 32'd0);
    chk("rs_err", 32'(err), 32'd0);
    chk("rs_en", 32'(spi_en), 32'd0);
    chk("rs_cs_n", 32'(cs_n), 32'hF);
    chk("rs_rdata", rdata, 32'd0);
    chk("rs_wdata", spi_wdata, 32'd0);
    chk("rs_wbytes", 32'(spi_wbytes), 32'd0);
    rst = 0;
    for (int k = 0; k < N; k++) set_req(k, $urandom, 3'd1);
    @(negedge clk);
    chk("rs_regrant", 32'(gnt), 32'b0001);
    req = '0;
    m_stall = 0;
    settle();

    // randomized traffic
    m_wild = 1;
    for (int c = 0; c < 12000; c++) begin
      @(negedge clk);
      if (c == 6000) rst = 1;
      else if (c == 6002) rst = 0;
      for (int k = 0; k < N; k++) begin
        if (req[k]) begin
          if (done[k]) req[k] = 1'b0;
          else if (gnt[k] && spi_en && $urandom_range(0, 63) == 0)
            req[k] = 1'b0;
        end else if ($urandom_range(0, 15) == 0) begin
          set_req(k, $urandom, rand_bytes());
        end
      end
    end
    req = '0;
    settle();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2_000_000;
    failures++;
    $display("FAIL watchdog: got timeout expected finish");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
